bsg_trace_replay_sequencer: RTL and testbench

Controller that sequences and shares a bank of FSB trace-replay test nodes, each a master with its own trace ROM, on one ring output. It gates each node's enable, watches per-node done/error, and merges the node output channels onto a single ring link. In sequential mode it merges by running one node at a time; in parallel mode it merges by round-robin arbitration. A watchdog flags a stalled run. It sits between the test-node bank and the FSB ring, replacing a per-node `$finish` with a single aggregated done/error report.

---
 rtl/bsg_trace_seq_pkg.sv | 19 +
 rtl/bsg_trace_seq_rr_arb.sv | 45 ++++
 rtl/bsg_trace_replay_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_bsg_trace_replay_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_trace_seq_pkg.sv
// Shared types and constants for the trace-replay sequencer.
//   bsg_trace_seq_state_e : controller state encoding
//   wd_sat_c              : all-ones pattern; the top slices timeout_width_p bits
//                           from it to get the watchdog saturation value
//                           (timeout_width_p must be in 2..wd_max_width_c)
package bsg_trace_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSeq,
      StPar,
      StDone,
      StFail
   } bsg_trace_seq_state_e;

   localparam int unsigned wd_max_width_c = 64;
   localparam logic [wd_max_width_c-1:0] wd_sat_c = '1;

endpackage

// File: rtl/bsg_trace_seq_rr_arb.sv
// Round-robin index picker for the parallel-mode merge.
//   reqs         : per-node request (node valid)
//   ptr          : search start; when hold=1 it is returned unchanged as the grant
//   hold         : keep the previously offered grant (packet not yet consumed)
//   grant        : granted node index
//   grant_onehot : one-hot form of grant
// Purely combinational, so the late ring consume never passes through here.
module bsg_trace_seq_rr_arb
   import bsg_trace_seq_pkg::*;
#(
   parameter  int unsigned nodes_p  = 4,
   localparam int unsigned idx_w_lp = $clog2(nodes_p)
) (
   input  logic [nodes_p-1:0]  reqs,
   input  logic [idx_w_lp-1:0] ptr,
   input  logic                hold,
   output logic [idx_w_lp-1:0] grant,
   output logic [nodes_p-1:0]  grant_onehot
);

   logic                found;
   logic [idx_w_lp-1:0] cand;

   // First requester at or after ptr, wrapping; with no requester the grant is ptr.
   always_comb begin
      grant = ptr;
      found = 1'b0;
      cand  = ptr;
      if (!hold) begin
         for (int unsigned i = 0; i < nodes_p; i++) begin
            cand = idx_w_lp'((32'(ptr) + i) % nodes_p);
            if (!found && reqs[cand]) begin
               grant = cand;
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      grant_onehot        = '0;
      grant_onehot[grant] = 1'b1;
   end

endmodule

// File: rtl/bsg_trace_replay_sequencer.sv
// Sequences a bank of trace-replay nodes and merges their output channels onto
// one ring link, reporting a single aggregated done/error result.
//   clk_i, reset_i      : clock, synchronous active-low reset
//   start_i, parallel_i : launch a run (only from idle/done/fail) and pick its mode
//   node_en_o           : per-node enable
//   node_done_i/_error_i: per-node completion / failure levels
//   node_v_i/_data_i    : per-node output channel
//   node_yumi_o         : per-node consume, combinational from yumi_i
//   v_o, data_o, yumi_i : merged ring channel
//   done_o, error_o     : run finished / run failed
//   timeout_o           : the failure came from the watchdog
//   error_node_o        : index of the failing node
module bsg_trace_replay_sequencer
   import bsg_trace_seq_pkg::*;
#(
   parameter  int unsigned nodes_p         = 4,
   parameter  int unsigned ring_width_p    = 16,
   parameter  int unsigned timeout_width_p = 24,
   localparam int unsigned idx_w_lp        = $clog2(nodes_p)
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 start_i,
   input  logic                                 parallel_i,
   output logic [nodes_p-1:0]                   node_en_o,
   input  logic [nodes_p-1:0]                   node_done_i,
   input  logic [nodes_p-1:0]                   node_error_i,
   input  logic [nodes_p-1:0]                   node_v_i,
   input  logic [nodes_p-1:0][ring_width_p-1:0] node_data_i,
   output logic [nodes_p-1:0]                   node_yumi_o,
   output logic                                 v_o,
   output logic [ring_width_p-1:0]              data_o,
   input  logic                                 yumi_i,
   output logic                                 done_o,
   output logic                                 error_o,
   output logic                                 timeout_o,
   output logic [idx_w_lp-1:0]                  error_node_o
);

   localparam logic [timeout_width_p-1:0] wd_sat_lp = wd_sat_c[timeout_width_p-1:0];
   // Counter value whose increment would saturate: the trip point.
   localparam logic [timeout_width_p-1:0] wd_trip_lp = {wd_sat_lp[timeout_width_p-1:1], 1'b0};
   localparam logic [idx_w_lp-1:0]        last_idx_lp = idx_w_lp'(nodes_p - 1);

   bsg_trace_seq_state_e        state_q;
   logic [idx_w_lp-1:0]         idx_q;
   logic [idx_w_lp-1:0]         rr_ptr_q;
   logic [nodes_p-1:0]          done_mask_q;
   logic [timeout_width_p-1:0]  wd_q;
   logic                        lock_q;
   logic [idx_w_lp-1:0]         lock_idx_q;
   logic                        timeout_q;
   logic [idx_w_lp-1:0]         error_node_q;

   logic [nodes_p-1:0]  idx_onehot;
   logic [idx_w_lp-1:0] arb_ptr;
   logic [idx_w_lp-1:0] grant;
   logic [nodes_p-1:0]  grant_onehot;
   logic [idx_w_lp-1:0] lowest_err;
   logic                handshake;
   logic                new_done;

   assign idx_onehot = {{(nodes_p-1){1'b0}}, 1'b1} << idx_q;

   // While a packet is offered but not consumed, re-offer the same node.
   assign arb_ptr = lock_q ? lock_idx_q : rr_ptr_q;

   bsg_trace_seq_rr_arb #(
      .nodes_p (nodes_p)
   ) u_arb (
      .reqs         (node_v_i),
      .ptr          (arb_ptr),
      .hold         (lock_q),
      .grant        (grant),
      .grant_onehot (grant_onehot)
   );

   always_comb begin
      lowest_err = '0;
      for (int i = nodes_p - 1; i >= 0; i--) begin
         if (node_error_i[i]) lowest_err = idx_w_lp'(i);
      end
   end

   assign handshake = v_o & yumi_i;
   assign new_done  = |(node_done_i & ~done_mask_q);

   // Ring merge; yumi_i only ever gates, it never reaches a register on this path.
   always_comb begin
      v_o         = 1'b0;
      data_o      = '0;
      node_yumi_o = '0;
      unique case (state_q)
         StSeq: begin
            v_o         = node_v_i[idx_q];
            data_o      = node_data_i[idx_q];
            node_yumi_o = idx_onehot & {nodes_p{yumi_i}};
         end
         StPar: begin
            v_o         = |node_v_i;
            data_o      = node_data_i[grant];
            node_yumi_o = grant_onehot & {nodes_p{yumi_i}};
         end
         default: ;
      endcase
   end

   always_comb begin
      node_en_o = '0;
      unique case (state_q)
         StSeq:   node_en_o = idx_onehot;
         StPar:   node_en_o = '1;
         default: ;
      endcase
   end

   assign done_o       = (state_q == StDone) || (state_q == StFail);
   assign error_o      = (state_q == StFail);
   assign timeout_o    = timeout_q;
   assign error_node_o = error_node_q;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         rr_ptr_q     <= '0;
         done_mask_q  <= '0;
         wd_q         <= '0;
         lock_q       <= 1'b0;
         lock_idx_q   <= '0;
         timeout_q    <= 1'b0;
         error_node_q <= '0;
      end else begin
         lock_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone, StFail: begin
               if (start_i) begin
                  state_q      <= parallel_i ? StPar : StSeq;
                  idx_q        <= '0;
                  done_mask_q  <= '0;
                  wd_q         <= '0;
                  timeout_q    <= 1'b0;
                  error_node_q <= '0;
               end
            end
            StSeq: begin
               if (node_error_i[idx_q]) begin
                  state_q      <= StFail;
                  error_node_q <= idx_q;
               end else if (node_done_i[idx_q]) begin
                  if (idx_q == last_idx_lp) begin
                     state_q <= StDone;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                     wd_q  <= '0;
                  end
               end else if (handshake) begin
                  wd_q <= '0;
               end else if (wd_q == wd_trip_lp) begin
                  state_q      <= StFail;
                  timeout_q    <= 1'b1;
                  error_node_q <= idx_q;
                  wd_q         <= wd_sat_lp;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            StPar: begin
               done_mask_q <= done_mask_q | node_done_i;
               lock_q      <= v_o & ~yumi_i;
               lock_idx_q  <= grant;
               if (handshake) begin
                  rr_ptr_q <= (grant == last_idx_lp) ? '0 : grant + 1'b1;
               end
               if (|node_error_i) begin
                  state_q      <= StFail;
                  error_node_q <= lowest_err;
               end else if (&(done_mask_q | node_done_i)) begin
                  state_q <= StDone;
               end else if (handshake || new_done) begin
                  wd_q <= '0;
               end else if (wd_q == wd_trip_lp) begin
                  state_q      <= StFail;
                  timeout_q    <= 1'b1;
                  error_node_q <= rr_ptr_q;
                  wd_q         <= wd_sat_lp;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bsg_trace_replay_sequencer.sv
// Randomised bench: a node-bank model and a run-level reference model drive the
// sequencer; expected ring/status outputs are queued per cycle and a separate
// monitor pops and compares them away from the clock edge.
module tb_bsg_trace_replay_sequencer;

   localparam int N  = 4;
   localparam int RW = 16;
   localparam int TW = 4;
   // Idle cycles allowed before the watchdog reaches all ones: 2^TW - 1.
   localparam int WD_IDLE = (1 << TW) - 1;
   localparam int BUDGET  = 300;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   reset_i = 1'b0;
   logic                   start_i = 1'b0;
   logic                   parallel_i = 1'b0;
   logic [N-1:0]           node_en_o;
   logic [N-1:0]           node_done_i = '0;
   logic [N-1:0]           node_error_i = '0;
   logic [N-1:0]           node_v_i = '0;
   logic [N-1:0][RW-1:0]   node_data_i = '0;
   logic [N-1:0]           node_yumi_o;
   logic                   v_o;
   logic [RW-1:0]          data_o;
   logic                   yumi_i = 1'b0;
   logic                   done_o;
   logic                   error_o;
   logic                   timeout_o;
   logic [1:0]             error_node_o;

   bsg_trace_replay_sequencer #(
      .nodes_p         (N),
      .ring_width_p    (RW),
      .timeout_width_p (TW)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .parallel_i   (parallel_i),
      .node_en_o    (node_en_o),
      .node_done_i  (node_done_i),
      .node_error_i (node_error_i),
      .node_v_i     (node_v_i),
      .node_data_i  (node_data_i),
      .node_yumi_o  (node_yumi_o),
      .v_o          (v_o),
      .data_o       (data_o),
      .yumi_i       (yumi_i),
      .done_o       (done_o),
      .error_o      (error_o),
      .timeout_o    (timeout_o),
      .error_node_o (error_node_o)
   );

   typedef struct {
      logic          v;
      logic          cd;
      logic [RW-1:0] data;
      logic [N-1:0]  yumi;
      logic [N-1:0]  en;
      logic          done;
      logic          err;
      logic          to;
      logic [1:0]    enode;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   hs_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queued expectation.
   always begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("v_o", 32'(v_o), 32'(mon_e.v));
         if (mon_e.cd) chk("data_o", 32'(data_o), 32'(mon_e.data));
         chk("node_yumi_o", 32'(node_yumi_o), 32'(mon_e.yumi));
         chk("node_en_o", 32'(node_en_o), 32'(mon_e.en));
         chk("done_o", 32'(done_o), 32'(mon_e.done));
         chk("error_o", 32'(error_o), 32'(mon_e.err));
         chk("timeout_o", 32'(timeout_o), 32'(mon_e.to));
         chk("error_node_o", 32'(error_node_o), 32'(mon_e.enode));
         if (v_o && yumi_i) hs_cnt++;
      end
   end

   // Reference model: run state 0 idle, 1 seq, 2 par, 3 done, 4 fail.
   int         st = 0;
   int         cur = 0;
   int         rr = 0;
   int         lock = -1;
   int         idle_cnt = 0;
   logic [N-1:0] mask = '0;
   logic       m_to = 1'b0;
   logic [1:0] m_enode = 2'd0;

   // Node bank model.
   int           rem[N];
   int           seqno[N];
   bit           pend[N];
   int           vprob = 100;
   int           yprob = 100;
   logic [N-1:0] silent = '0;
   logic [N-1:0] errm = '0;

   function automatic int pick(input logic [N-1:0] v);
      if (lock >= 0) return lock;
      for (int k = 0; k < N; k++) begin
         if (v[(rr + k) % N]) return (rr + k) % N;
      end
      return rr;
   endfunction

   task automatic consume(input int i);
      rem[i]--;
      pend[i] = 0;
      seqno[i]++;
   endtask

   task automatic one_cycle(input bit start, input bit par, input bit rst, input bit yblock);
      logic [N-1:0]         en;
      logic [N-1:0]         v;
      logic [N-1:0]         dn;
      logic [N-1:0]         er;
      logic [N-1:0][RW-1:0] d;
      int                   g;
      bit                   ev;
      bit                   y;
      bit                   nd;
      bit                   idle;
      exp_t                 e;
      en = '0;
      if (st == 1) en[cur] = 1'b1;
      else if (st == 2) en = '1;
      for (int i = 0; i < N; i++) begin
         if (en[i] && !pend[i] && rem[i] > 0 && !silent[i] && $urandom_range(99) < vprob)
            pend[i] = 1;
         v[i]  = en[i] && pend[i];
         d[i]  = {8'(i), 8'(seqno[i])};
         dn[i] = en[i] && rem[i] == 0 && !silent[i];
         er[i] = dn[i] && errm[i];
      end
      g  = (st == 1) ? cur : pick(v);
      ev = (st == 1) ? v[cur] : (st == 2) ? |v : 1'b0;
      y  = ev && !yblock && ($urandom_range(99) < yprob);
      e.v    = ev;
      e.cd   = (st == 1) || ev || (st != 2);
      e.data = (st == 1 || st == 2) ? d[g] : '0;
      e.yumi = '0;
      if (y) e.yumi[g] = 1'b1;
      e.en    = en;
      e.done  = (st == 3 || st == 4);
      e.err   = (st == 4);
      e.to    = m_to;
      e.enode = m_enode;
      exp_q.push_back(e);
      start_i      = start;
      parallel_i   = par;
      reset_i      = !rst;
      node_v_i     = v;
      node_data_i  = d;
      node_done_i  = dn;
      node_error_i = er;
      yumi_i       = y;
      @(posedge clk);
      if (rst) begin
         st = 0; cur = 0; rr = 0; lock = -1; idle_cnt = 0; mask = '0;
         m_to = 1'b0; m_enode = 2'd0;
      end else if (st == 0 || st == 3 || st == 4) begin
         if (start) begin
            st = par ? 2 : 1; cur = 0; mask = '0; idle_cnt = 0; lock = -1;
            m_to = 1'b0; m_enode = 2'd0;
         end
      end else begin
         // Watchdog: a cycle with neither consume nor new done is idle.
         nd   = (st == 1) ? dn[cur] : |(dn & ~mask);
         idle = !y && !nd;
         if (y) consume(g);
         if (st == 2) begin
            if (y) begin
               rr = (g + 1) % N;
               lock = -1;
            end else if (ev) begin
               lock = g;
            end
         end
         idle_cnt = idle ? idle_cnt + 1 : 0;
         if (st == 1) begin
            if (er[cur]) begin
               st = 4; m_enode = 2'(cur);
            end else if (dn[cur]) begin
               if (cur == N - 1) st = 3;
               else cur++;
            end else if (idle_cnt == WD_IDLE) begin
               st = 4; m_to = 1'b1; m_enode = 2'(cur);
            end
         end else begin
            mask = mask | dn;
            if (|er) begin
               st = 4;
               for (int i = N - 1; i >= 0; i--) if (er[i]) m_enode = 2'(i);
            end else if (&mask) begin
               st = 3;
            end else if (idle_cnt == WD_IDLE) begin
               st = 4; m_to = 1'b1; m_enode = 2'(rr);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic run(input bit par, input int nrem, input int vp, input int yp,
                      input logic [N-1:0] sil, input logic [N-1:0] erm,
                      input int rst_at, input int start_at, input int yb_from, input int yb_len);
      int cyc;
      vprob  = vp;
      yprob  = yp;
      silent = sil;
      errm   = erm;
      for (int i = 0; i < N; i++) begin
         rem[i]   = nrem;
         seqno[i] = 0;
         pend[i]  = 0;
      end
      hs_cnt = 0;
      one_cycle(1'b1, par, 1'b0, 1'b0);
      cyc = 1;
      while ((st == 1 || st == 2) && cyc < BUDGET) begin
         one_cycle(cyc == start_at, par, cyc == rst_at,
                   cyc >= yb_from && cyc < yb_from + yb_len);
         cyc++;
      end
      if (st == 1 || st == 2) begin
         n_chk++;
         n_fail++;
         $display("FAIL run_budget: run still active after %0d cycles, required finished", cyc);
      end
      one_cycle(1'b0, par, 1'b0, 1'b0);
      one_cycle(1'b0, par, 1'b0, 1'b0);
   endtask

   initial begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) one_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) one_cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // Sequential, 3 packets per node.
      run(1'b0, 3, 70, 70, '0, '0, -1, -1, -1, 0);
      chk("seq_packet_count", 32'(hs_cnt), 32'd12);
      chk("seq_error", 32'(error_o), 32'd0);

      // Parallel, everyone always valid, ring always consuming.
      run(1'b1, 5, 100, 100, '0, '0, -1, -1, -1, 0);
      chk("par_packet_count", 32'(hs_cnt), 32'd20);

      // Parallel with a 5-cycle consume stall while all nodes request.
      run(1'b1, 4, 100, 100, '0, '0, -1, -1, 3, 5);

      // Sequential, node 2 raises error together with done.
      run(1'b0, 3, 80, 80, '0, 4'b0100, -1, -1, -1, 0);
      chk("err_node_idx", 32'(error_node_o), 32'd2);
      chk("err_en_off", 32'(node_en_o), 32'd0);
      chk("err_flag", 32'(error_o), 32'd1);

      // Sequential, node 1 silent: watchdog trips.
      run(1'b0, 2, 80, 80, 4'b0010, '0, -1, -1, -1, 0);
      chk("to_flag", 32'(timeout_o), 32'd1);
      chk("to_node", 32'(error_node_o), 32'd1);

      // Restart clears the flags and begins at node 0.
      run(1'b0, 2, 80, 80, '0, '0, -1, -1, -1, 0);
      chk("restart_to_clear", 32'(timeout_o), 32'd0);

      // Reset in the middle of a parallel run.
      run(1'b1, 6, 70, 70, '0, '0, 6, -1, -1, 0);
      chk("rst_en", 32'(node_en_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);

      // start_i pulsed mid sequential run is ignored.
      run(1'b0, 2, 80, 80, '0, '0, -1, 4, -1, 0);

      for (int r = 0; r < 6; r++) begin
         run(1'($urandom_range(1)), int'($urandom_range(1, 4)), 60, 60,
             '0, '0, -1, -1, -1, 0);
      end

      #5;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
